// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : MIPS pipeline memory-access stage. Drives the data-memory
//               port for LW/LB/LBU/SW/SB and forms the MEM->WB bus.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage (
    input  logic         clk,
    input  logic         rst,
    input  logic         MEM_valid,
    input  logic [153:0] EXE_MEM_bus_r,
    input  logic [31:0]  dm_rdata,
    input  logic         MEM_allow_in,
    output logic [31:0]  dm_addr,
    output logic [3:0]   dm_wen,
    output logic [31:0]  dm_wdata,
    output logic         MEM_over,
    output logic [117:0] MEM_WB_bus,
    output logic [4:0]   MEM_wdest,
    output logic [31:0]  MEM_pc
);

    logic        w_inst_load;
    logic        w_inst_store;
    logic        w_ls_word;
    logic        w_lb_sign;
    logic [31:0] w_store_data;
    logic [31:0] w_exe_result;
    logic [31:0] w_lo_result;
    logic        w_hi_write;
    logic        w_lo_write;
    logic        w_mfhi;
    logic        w_mflo;
    logic        w_mtc0;
    logic        w_mfc0;
    logic [7:0]  w_cp0r_addr;
    logic        w_syscall;
    logic        w_eret;
    logic        w_rf_wen;
    logic [4:0]  w_rf_wdest;
    logic [31:0] w_pc;

    logic [7:0]  w_load_byte;
    logic [31:0] w_load_result;
    logic [31:0] w_mem_result;

    logic        r_mem_valid;

    assign {w_inst_load, w_inst_store, w_ls_word, w_lb_sign,
            w_store_data, w_exe_result, w_lo_result,
            w_hi_write, w_lo_write, w_mfhi, w_mflo, w_mtc0, w_mfc0,
            w_cp0r_addr, w_syscall, w_eret, w_rf_wen, w_rf_wdest,
            w_pc} = EXE_MEM_bus_r;

    assign dm_addr = w_exe_result;

    always_comb begin
        dm_wen   = 4'b0000;
        dm_wdata = w_store_data;
        if (!w_ls_word) begin
            dm_wdata = {4{w_store_data[7:0]}};
        end
        if (w_inst_store && MEM_valid) begin
            if (w_ls_word) begin
                dm_wen = 4'b1111;
            end else begin
                case (w_exe_result[1:0])
                    2'd0:    dm_wen = 4'b0001;
                    2'd1:    dm_wen = 4'b0010;
                    2'd2:    dm_wen = 4'b0100;
                    default: dm_wen = 4'b1000;
                endcase
            end
        end
    end

    // Little-endian lane select for byte loads.
    always_comb begin
        case (w_exe_result[1:0])
            2'd0:    w_load_byte = dm_rdata[7:0];
            2'd1:    w_load_byte = dm_rdata[15:8];
            2'd2:    w_load_byte = dm_rdata[23:16];
            default: w_load_byte = dm_rdata[31:24];
        endcase
    end

    always_comb begin
        if (w_ls_word) begin
            w_load_result = dm_rdata;
        end else begin
            w_load_result = {{24{w_lb_sign & w_load_byte[7]}}, w_load_byte};
        end
    end

    assign w_mem_result = w_inst_load ? w_load_result : w_exe_result;

    // A load's data arrives one cycle after the address; this flag marks
    // that the held load has waited that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_valid <= 1'b0;
        end else if (MEM_allow_in) begin
            r_mem_valid <= 1'b0;
        end else begin
            r_mem_valid <= MEM_valid;
        end
    end

    assign MEM_over = w_inst_load ? r_mem_valid : MEM_valid;

    assign MEM_WB_bus = {w_rf_wen, w_rf_wdest, w_mem_result, w_lo_result,
                         w_hi_write, w_lo_write, w_mfhi, w_mflo, w_mtc0, w_mfc0,
                         w_cp0r_addr, w_syscall, w_eret, w_pc};

    assign MEM_wdest = w_rf_wdest & {5{MEM_valid}};
    assign MEM_pc    = w_pc;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Self-checking bench for mem_stage: directed literal cases
//               plus randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    logic         clk;
    logic         rst;
    logic         MEM_valid;
    logic [153:0] EXE_MEM_bus_r;
    logic [31:0]  dm_rdata;
    logic         MEM_allow_in;
    logic [31:0]  dm_addr;
    logic [3:0]   dm_wen;
    logic [31:0]  dm_wdata;
    logic         MEM_over;
    logic [117:0] MEM_WB_bus;
    logic [4:0]   MEM_wdest;
    logic [31:0]  MEM_pc;

    // Instruction fields driven by the stimulus
    logic        f_load, f_store, f_word, f_sign;
    logic [31:0] f_sdata, f_exe, f_lo, f_pc;
    logic [5:0]  f_flags;
    logic [7:0]  f_cp0;
    logic        f_sys, f_eret, f_rfwen;
    logic [4:0]  f_wdest;

    int checks;
    int failures;
    bit chk_en;
    bit m_load_waited;

    assign EXE_MEM_bus_r = {f_load, f_store, f_word, f_sign, f_sdata, f_exe, f_lo,
                            f_flags, f_cp0, f_sys, f_eret, f_rfwen, f_wdest, f_pc};

    mem_stage dut (
        .clk          (clk),
        .rst          (rst),
        .MEM_valid    (MEM_valid),
        .EXE_MEM_bus_r(EXE_MEM_bus_r),
        .dm_rdata     (dm_rdata),
        .MEM_allow_in (MEM_allow_in),
        .dm_addr      (dm_addr),
        .dm_wen       (dm_wen),
        .dm_wdata     (dm_wdata),
        .MEM_over     (MEM_over),
        .MEM_WB_bus   (MEM_WB_bus),
        .MEM_wdest    (MEM_wdest),
        .MEM_pc       (MEM_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [153:0] act, input logic [153:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected result of the memory stage computed from the field values.
    function automatic logic [31:0] model_result();
        logic [31:0] b;
        if (!f_load) return f_exe;
        if (f_word) return dm_rdata;
        b = (dm_rdata >> (8 * f_exe[1:0])) & 32'h0000_00FF;
        if (f_sign && b >= 32'h80) b = b + 32'hFFFF_FF00;
        return b;
    endfunction

    function automatic logic [3:0] model_wen();
        if (!(f_store && MEM_valid)) return 4'd0;
        if (f_word) return 4'hF;
        return 4'(1 << f_exe[1:0]);
    endfunction

    // A load is complete once it was held valid across an edge with no
    // acceptance of a new instruction and no reset.
    always @(posedge clk) begin
        m_load_waited = !rst && !MEM_allow_in && MEM_valid;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] exp_wdata;
            exp_wdata = f_word ? f_sdata : f_sdata[7:0] * 32'h0101_0101;
            check("dm_addr", dm_addr, f_exe);
            check("dm_wen", dm_wen, model_wen());
            check("dm_wdata", dm_wdata, exp_wdata);
            check("MEM_over", MEM_over, f_load ? m_load_waited : MEM_valid);
            check("MEM_WB_bus", MEM_WB_bus,
                  {f_rfwen, f_wdest, model_result(), f_lo, f_flags, f_cp0, f_sys, f_eret, f_pc});
            check("MEM_wdest", MEM_wdest, MEM_valid ? f_wdest : 5'd0);
            check("MEM_pc", MEM_pc, f_pc);
        end
    end

    task automatic clear_fields();
        {f_load, f_store, f_word, f_sign} = 4'b0;
        f_sdata = '0; f_exe = '0; f_lo = '0; f_pc = '0;
        f_flags = '0; f_cp0 = '0; f_sys = 1'b0; f_eret = 1'b0;
        f_rfwen = 1'b0; f_wdest = '0;
    endtask

    // Advance to just after the next falling edge, where directed checks sample.
    task automatic to_sample();
        @(negedge clk);
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0; failures = 0; chk_en = 0; m_load_waited = 0;
        rst = 1'b1; MEM_valid = 1'b0; MEM_allow_in = 1'b0; dm_rdata = '0;
        clear_fields();
        repeat (2) next_cycle();
        chk_en = 1;
        to_sample();
        check("reset_over", MEM_over, 1'b0);
        next_cycle();
        rst = 1'b0;

        // Pass-through of a non-load
        f_lo = 32'd123; f_flags = 6'b110000; f_pc = 32'd34;
        to_sample();
        check("pt_over_invalid", MEM_over, 1'b0);
        next_cycle();
        MEM_valid = 1'b1;
        to_sample();
        check("pt_over_valid", MEM_over, 1'b1);
        check("pt_wen", dm_wen, 4'b0000);
        check("pt_bus", MEM_WB_bus, {1'b0, 5'd0, 32'd0, 32'd123, 6'b110000, 8'd0, 2'b00, 32'd34});
        check("pt_pc", MEM_pc, 32'd34);
        next_cycle();

        // Word store
        clear_fields();
        f_store = 1'b1; f_word = 1'b1; f_exe = 32'h100; f_sdata = 32'hDEAD_BEEF;
        to_sample();
        check("sw_wen", dm_wen, 4'b1111);
        check("sw_wdata", dm_wdata, 32'hDEAD_BEEF);
        check("sw_addr", dm_addr, 32'h100);
        next_cycle();
        MEM_valid = 1'b0;
        to_sample();
        check("sw_wen_invalid", dm_wen, 4'b0000);
        next_cycle();
        MEM_valid = 1'b1;

        // Byte stores
        f_word = 1'b0; f_sdata = 32'h1234_5678; f_exe = 32'h101;
        to_sample();
        check("sb1_wen", dm_wen, 4'b0010);
        check("sb1_wdata", dm_wdata, 32'h7878_7878);
        next_cycle();
        f_exe = 32'h103;
        to_sample();
        check("sb3_wen", dm_wen, 4'b1000);
        next_cycle();

        // Byte loads
        clear_fields();
        dm_rdata = 32'h80FF_7F01; f_load = 1'b1;
        f_sign = 1'b1; f_exe = 32'h2;
        to_sample();
        check("lb2", MEM_WB_bus[111:80], 32'hFFFF_FFFF);
        next_cycle();
        f_sign = 1'b0;
        to_sample();
        check("lbu2", MEM_WB_bus[111:80], 32'h0000_00FF);
        next_cycle();
        f_sign = 1'b1; f_exe = 32'h3;
        to_sample();
        check("lb3", MEM_WB_bus[111:80], 32'hFFFF_FF80);
        next_cycle();
        f_exe = 32'h1;
        to_sample();
        check("lb1", MEM_WB_bus[111:80], 32'h0000_007F);
        next_cycle();

        // Load latency, then drop by acceptance and by reset
        MEM_valid = 1'b0;
        next_cycle();
        f_word = 1'b1; f_exe = 32'h40; dm_rdata = 32'hCAFE_F00D; MEM_valid = 1'b1;
        to_sample();
        check("lw_over_first", MEM_over, 1'b0);
        check("lw_result", MEM_WB_bus[111:80], 32'hCAFE_F00D);
        next_cycle();
        to_sample();
        check("lw_over_second", MEM_over, 1'b1);
        MEM_allow_in = 1'b1;
        next_cycle();
        MEM_allow_in = 1'b0;
        to_sample();
        check("lw_over_after_allow", MEM_over, 1'b0);
        next_cycle();
        to_sample();
        check("lw_over_rewait", MEM_over, 1'b1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        to_sample();
        check("lw_over_after_rst", MEM_over, 1'b0);
        next_cycle();

        // Destination masking
        clear_fields();
        f_wdest = 5'd17; MEM_valid = 1'b1;
        to_sample();
        check("wdest_valid", MEM_wdest, 5'd17);
        next_cycle();
        MEM_valid = 1'b0;
        to_sample();
        check("wdest_invalid", MEM_wdest, 5'd0);
        next_cycle();

        // Randomized traffic, checked every cycle by the compare process
        for (int i = 0; i < 400; i++) begin
            {f_load, f_store, f_word, f_sign} = 4'($urandom);
            if (f_load && f_store) f_store = 1'b0;
            f_sdata = $urandom; f_exe = $urandom; f_lo = $urandom; f_pc = $urandom;
            f_flags = 6'($urandom); f_cp0 = 8'($urandom);
            f_sys = 1'($urandom); f_eret = 1'($urandom);
            f_rfwen = 1'($urandom); f_wdest = 5'($urandom);
            dm_rdata = $urandom;
            MEM_valid = ($urandom_range(0, 3) != 0);
            MEM_allow_in = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 31) == 0);
            next_cycle();
        end
        rst = 1'b0; MEM_valid = 1'b0; MEM_allow_in = 1'b0;
        to_sample();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
